// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the status-flag layout used by
// both the adder and subtractor pipelines.
package alu_pkg;
  localparam int DATA_W  = 64;
  localparam int SLICE_W = 16;
  localparam int GRP_W   = 4;

  typedef struct packed {
    logic borrow;
    logic ovf;
    logic zero;
  } alu_flags_t;

  // Two's-complement overflow of a - b, from the operand and result sign bits.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction
endpackage

// File: rtl/sub64_pipe_if.sv
// Streaming operand/result bus for the pipelined subtractor.
interface sub64_pipe_if #(parameter int WIDTH = alu_pkg::DATA_W);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf, zero);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf, zero);
endinterface

// File: rtl/sub_slice16.sv
// Combinational slice adder (a + b_inv + cin) built as a carry-select of
// short ripple groups, matching the timing style of the companion adder.
module sub_slice16 import alu_pkg::*; #(
  parameter int W = SLICE_W,
  parameter int G = GRP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NG = W / G;

  logic [NG:0] c;
  assign c[0] = cin;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [G:0] s0, s1;
    assign s0 = {1'b0, a[g*G +: G]} + {1'b0, b_inv[g*G +: G]};
    // s0 never exceeds 2^(G+1)-2, so the +1 variant cannot wrap.
    assign s1 = s0 + {{G{1'b0}}, 1'b1};
    assign sum[g*G +: G] = c[g] ? s1[G-1:0] : s0[G-1:0];
    assign c[g+1]        = c[g] ? s1[G]     : s0[G];
  end

  assign cout = c[NG];
endmodule

// File: rtl/sub64_pipe.sv
// Pipelined subtractor: one SLICE-bit slice of a + ~b + 1 resolved per stage,
// carry registered between stages, global stall driven by output backpressure.
module sub64_pipe import alu_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = SLICE_W
) (
  input  logic       clk,
  input  logic       rst,
  sub64_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;

  logic advance, in_fire;

  logic [STAGES-1:0]            vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d, opbn_q, opbn_d, res_q, res_d;
  logic [STAGES-1:0]            cy_q, cy_d;

  // Operands feeding the slice computed by each stage.
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_bn, src_res;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][SLICE-1:0] slice_sum;
  logic [STAGES-1:0]            slice_cout;

  assign vld_pipe     = {vld_pipe_q, in_fire};
  assign bus.out_valid = vld_pipe[STAGES];
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign in_fire      = bus.in_valid && advance;

  always_comb begin
    src_a[0]   = bus.a;
    src_bn[0]  = ~bus.b;
    src_c[0]   = 1'b1;
    src_res[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      src_a[i]   = opa_q[i-1];
      src_bn[i]  = opbn_q[i-1];
      src_c[i]   = cy_q[i-1];
      src_res[i] = res_q[i-1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    sub_slice16 #(.W(SLICE)) u_slice (
      .a     (src_a[i][i*SLICE +: SLICE]),
      .b_inv (src_bn[i][i*SLICE +: SLICE]),
      .cin   (src_c[i]),
      .sum   (slice_sum[i]),
      .cout  (slice_cout[i])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    opa_d      = opa_q;
    opbn_d     = opbn_q;
    res_d      = res_q;
    cy_d       = cy_q;
    if (advance) begin
      vld_pipe_d = vld_pipe[STAGES-1:0];
      for (int i = 0; i < STAGES; i++) begin
        opa_d[i]                   = src_a[i];
        opbn_d[i]                  = src_bn[i];
        res_d[i]                   = src_res[i];
        res_d[i][i*SLICE +: SLICE] = slice_sum[i];
        cy_d[i]                    = slice_cout[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      opa_q      <= '0;
      opbn_q     <= '0;
      res_q      <= '0;
      cy_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      opa_q      <= opa_d;
      opbn_q     <= opbn_d;
      res_q      <= res_d;
      cy_q       <= cy_d;
    end
  end

  // Outputs are masked by out_valid so bubble contents never leak.
  alu_flags_t flags;
  always_comb begin
    flags.borrow = bus.out_valid & ~cy_q[STAGES-1];
    flags.ovf    = bus.out_valid & sub_ovf(opa_q[STAGES-1][WIDTH-1],
                                           ~opbn_q[STAGES-1][WIDTH-1],
                                           res_q[STAGES-1][WIDTH-1]);
    flags.zero   = bus.out_valid & (res_q[STAGES-1] == '0);
  end

  assign bus.diff   = bus.out_valid ? res_q[STAGES-1] : '0;
  assign bus.borrow = flags.borrow;
  assign bus.ovf    = flags.ovf;
  assign bus.zero   = flags.zero;
endmodule

// File: doc/sub64_pipe.md
Name: sub64_pipe

Overview:
- 64-bit pipelined subtractor: diff = a - b, computed as a + ~b + 1.
- It is the inverse-direction companion to the team's 64-bit carry-select adder.
- The datapath is split into 16-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Valid/ready handshakes on input and output let it sit in streaming ALU datapaths with backpressure.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of SLICE.
- SLICE, 16, bits resolved per pipeline stage.
- STAGES = WIDTH/SLICE (default 4): derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned); equals the inverted final carry.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].
- zero  output  1  diff == 0.

Behaviour:
- Reset: all valid bits, all carry registers and all partial-result registers clear to 0.
  - Outputs after reset: out_valid=0, diff=0, borrow=0, ovf=0, zero=0, in_ready=1.
- Global stall: advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance=0, every stage register holds its value.
- Input transfer: occurs when in_valid && in_ready.
  - Stage 1 captures a and b, computes slice 0 using carry-in 1 (the +1 of two's complement), and registers:
    - sum slice 0;
    - carry out;
    - remaining upper slices of a and ~b.
  - Stage k (k=2..STAGES): adds slice k-1 of the stored a and ~b using the registered carry from stage k-1. It forwards the lower result slices already computed, plus the still-unresolved upper operand slices.
- Per-stage valid:
  - v[1] <= in_valid && in_ready; v[k] <= v[k-1], both gated by advance.
  - out_valid = v[STAGES].
- Latency and throughput:
  - Latency is exactly STAGES cycles (4 at default) from input transfer to out_valid with out_ready held high.
  - Throughput is 1 result per cycle with no bubbles.
- Flag rules:
  - borrow = ~carry_out of the top slice.
  - zero is computed from the full registered diff in the last stage (combinational on diff is allowed).
  - ovf uses the stored MSBs of a and b, carried along to the last stage.
- Output hold: while out_valid && !out_ready, diff, borrow, ovf and zero are held stable; nothing upstream changes.
- Bubbles: a stage with v=0 may carry don't-care data, but its content must never become visible while out_valid=0.
- Simultaneous output drain and input accept in the same cycle is allowed; there is no loss or duplication.
- Reset asserted mid-operation: all in-flight results are discarded. The next cycle shows out_valid=0 and in_ready=1.
- Boundary values:
  - 0 - 1 gives diff=all-ones and borrow=1.
  - a == b gives diff=0, zero=1, borrow=0.
  - Most negative minus 1 gives ovf=1.

Decomposition:
- Shared package (alu_pkg):
  - localparam DATA_W=64;
  - localparam SLICE_W=16;
  - result struct / flag bit indices {borrow, ovf, zero} shared with the adder-side status logic.
- One sub-module, sub_slice16: combinational SLICE-bit adder with inputs a, b_inv and cin, and outputs sum and cout.
  - Internally it is a carry-select of 4-bit ripple groups, to match the adder's timing style.
  - It is instantiated STAGES times.

Test Plan:
- Basic: a=100, b=58, out_ready=1 -> after exactly 4 cycles out_valid=1, diff=42, borrow=0, ovf=0, zero=0.
- Borrow/wrap: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0. Then a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, borrow=0.
- Cross-slice carry chain: a=0x0001_0000_0000_0000, b=1 -> diff=0x0000_FFFF_FFFF_FFFF, which checks borrow propagation through all stages. Then a=b=0xDEAD_BEEF_0123_4567 -> diff=0, zero=1.
- Streaming: 8 back-to-back random pairs with out_ready=1 -> 8 consecutive out_valid cycles; results in order and equal to the reference model.
- Backpressure:
  - Stream 6 pairs, and drop out_ready for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall; diff/flags stable; no result lost or duplicated; order preserved.
- Reset mid-flight: 3 pairs in flight, then assert rst for 1 cycle -> out_valid=0 for the next 4 cycles with no new input, in_ready=1 right after reset, and no stale result ever emerges.
